// File: rtl/matrix_row_scanner.sv
// Time-multiplexed row scanner for a ROWS x COLS LED matrix with a double-buffered frame.
// Optional MATRIX_BLANKING_EN inserts a one-cycle dark BLANK state between rows.
module matrix_row_scanner #(
  parameter int ROWS  = 7,
  parameter int COLS  = 5,
  parameter int DWELL = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ROWS*COLS-1:0] frame_in,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [ROWS-1:0]      row_sel,
  output logic [COLS-1:0]      col_out,
  output logic                 frame_start
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(DWELL - 1);

  typedef enum logic {SCAN, BLANK} state_t;

  state_t                 state, state_next;
  logic [ROW_W-1:0]       row, row_next, row_inc;
  logic [DW_W-1:0]        dwell, dwell_next;
  logic                   boundary;
  logic                   pending, pending_next;
  logic                   load, capture;
  logic [ROWS*COLS-1:0]   shadow, active;

  always_comb begin
    state_next   = state;
    row_next     = row;
    dwell_next   = dwell;
    boundary     = 1'b0;
    row_inc      = (row == ROW_LAST) ? '0 : row + 1'b1;
    case (state)
      SCAN: begin
        if (dwell == DW_LAST) begin
          dwell_next = '0;
`ifdef MATRIX_BLANKING_EN
          state_next = BLANK;
`else
          row_next   = row_inc;
          boundary   = (row == ROW_LAST);
`endif
        end else begin
          dwell_next = dwell + 1'b1;
        end
      end
      BLANK: begin
        state_next = SCAN;
        row_next   = row_inc;
        boundary   = (row == ROW_LAST);
      end
      default: state_next = SCAN;
    endcase

    // Ready is ~pending, so a capture can never coincide with a copy.
    load         = boundary & pending;
    capture      = frame_valid & ~pending;
    pending_next = pending;
    if (load)
      pending_next = 1'b0;
    else if (capture)
      pending_next = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      row         <= '0;
      dwell       <= '0;
      pending     <= 1'b0;
      shadow      <= '0;
      active      <= '0;
      frame_ready <= 1'b1;
      row_sel     <= '1;
      col_out     <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      row         <= row_next;
      dwell       <= dwell_next;
      pending     <= pending_next;
      frame_ready <= ~pending_next;
      if (load)
        active <= shadow;
      if (capture)
        shadow <= frame_in;
      if (state == BLANK) begin
        row_sel <= '1;
        col_out <= '0;
      end else begin
        row_sel <= ~(ROWS'(1) << row);
        col_out <= active[row*COLS +: COLS];
      end
      frame_start <= (state == SCAN) && (row == '0) && (dwell == '0);
    end
  end

endmodule

// File: tb/tb_matrix_row_scanner.sv
// Randomized bench for matrix_row_scanner against a time-index reference model.
// Define MATRIX_BLANKING_EN for both bench and RTL to check the blanking build.
module tb_matrix_row_scanner;

  localparam int ROWS  = 7;
  localparam int COLS  = 5;
  localparam int DWELL = 4;
`ifdef MATRIX_BLANKING_EN
  localparam int P = DWELL + 1;
`else
  localparam int P = DWELL;
`endif
  localparam int FP = ROWS * P;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ROWS*COLS-1:0] frame_in;
  logic                 frame_valid;
  logic                 frame_ready;
  logic [ROWS-1:0]      row_sel;
  logic [COLS-1:0]      col_out;
  logic                 frame_start;

  always #5 clk = ~clk;

  matrix_row_scanner #(.ROWS(ROWS), .COLS(COLS), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .frame_in(frame_in), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .row_sel(row_sel), .col_out(col_out),
    .frame_start(frame_start)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference: k = index of the output cycle since reset release.
  int                   k;
  logic                 m_pend;
  logic [ROWS*COLS-1:0] m_shadow, m_active;
  logic [ROWS-1:0]      exp_rs;
  logic [COLS-1:0]      exp_col;
  logic                 exp_fs, exp_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [ROWS*COLS-1:0] d);
    int row, w;
    rst = r;
    frame_valid = v;
    frame_in = d;
    if (r) begin
      k = 0; m_pend = 1'b0; m_shadow = '0; m_active = '0;
      exp_rs = '1; exp_col = '0; exp_fs = 1'b0; exp_rdy = 1'b1;
    end else begin
      row = (k / P) % ROWS;
      w   = k % P;
      if (w >= DWELL) begin
        exp_rs = '1; exp_col = '0;
      end else begin
        exp_rs  = ~(ROWS'(1) << row);
        exp_col = m_active[row*COLS +: COLS];
      end
      exp_fs = (k % FP) == 0;
      if ((k % FP) == FP - 1 && m_pend) begin
        m_active = m_shadow;
        m_pend = 1'b0;
      end else if (v && !m_pend) begin
        m_shadow = d;
        m_pend = 1'b1;
      end
      exp_rdy = !m_pend;
      k++;
    end
    @(negedge clk);
    chk("row_sel", 32'(row_sel), 32'(exp_rs));
    chk("col_out", 32'(col_out), 32'(exp_col));
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    chk("frame_ready", 32'(frame_ready), 32'(exp_rdy));
  endtask

  function automatic logic [ROWS*COLS-1:0] rnd_frame();
    logic [63:0] x;
    x = {$urandom(), $urandom()};
    return x[ROWS*COLS-1:0];
  endfunction

  initial begin
    logic [ROWS*COLS-1:0] f, f2;
    k = 0;
    repeat (3) step(1'b1, 1'b0, '0);
    repeat (2 * FP) step(1'b0, 1'b0, '0);

    // Row r carries r+1, offered mid-frame, then a second frame held while pending.
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = COLS'(r + 1);
    repeat (FP / 2) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, f);
    f2 = rnd_frame();
    repeat (2 * FP) step(1'b0, 1'b1, f2);
    repeat (2 * FP) step(1'b0, 1'b0, '0);

    // Offer a frame exactly on the boundary cycle with nothing pending.
    while ((k % FP) != FP - 1) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, rnd_frame());
    repeat (2 * FP + 2) step(1'b0, 1'b0, '0);

    // Reset during row 3 with a frame pending: it must never appear.
    while (((k / P) % ROWS) != 3) step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, rnd_frame());
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    repeat (2 * FP) step(1'b0, 1'b0, '0);

    repeat (1500)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 7) == 0, rnd_frame());

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matrix_row_scanner.md
# matrix_row_scanner

Time-multiplexed row scanner for the 5-column x 7-row LED dot-matrix display. Consumes the per-line column patterns produced by the line preset generators as a flattened frame and drives the physical matrix one row at a time. Uses a prescaled dwell counter and a double-buffered frame register with a valid/ready handshake, so a new frame takes effect only on a frame boundary and never tears mid-scan. Sits between the character/preset logic and the board pins.

## Interface
- ROWS, 7, number of matrix rows
- COLS, 5, columns per row
- DWELL, 50000, clock cycles each row stays lit; legal range 1..2^20-1
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous reset, active-high
- frame_in  in  ROWS*COLS  new frame; row r occupies bits [r*COLS +: COLS], bit 0 of each row = column 1
- frame_valid  in  1  frame_in valid this cycle
- frame_ready  out  1  shadow buffer free; transfer on frame_valid & frame_ready
- row_sel  out  ROWS  row enables, active-low, one-hot-low; bit r = row r
- col_out  out  COLS  column data for the selected row, active-high
- frame_start  out  1  one-cycle pulse on the first cycle of row 0

## Operation
- Registers: shadow (ROWS*COLS), pending (1), active (ROWS*COLS), row counter (0..ROWS-1), dwell counter (0..DWELL-1), state.
- Reset values: row_sel all 1s, col_out 0, frame_start 0, frame_ready 1, pending 0, shadow 0, active 0, row 0, dwell 0, state SCAN.
- Handshake: frame_ready = ~pending, registered. On frame_valid & frame_ready: shadow <= frame_in, pending <= 1. frame_valid without ready is ignored; the source holds its data.
- State SCAN: row_sel = ~(1 << row), col_out = active row slice. Dwell increments each cycle. At dwell == DWELL-1: dwell <= 0, row advances, wrapping ROWS-1 -> 0.
- Frame boundary = the last dwell cycle of row ROWS-1. At the boundary with pending = 1: active <= shadow, pending <= 0. Row 0 of the next frame shows the new data.
- Handshake and boundary in the same cycle: the boundary copies the old shadow contents only if pending was already 1. A frame captured in that cycle waits for the following boundary; there is no bypass path.
- frame_start = 1 on the first cycle row 0 is driven, every frame.
- Reset asserted mid-row or mid-handshake: all state returns to its reset values on the next edge. Any captured or pending frame is discarded and the display goes dark.

## Timing
- All outputs are registered. The first cycle after rst deasserts drives row 0 (row_sel = 7'b1111110) with col_out = 0, and frame_start = 1.
- Row period = DWELL cycles. Frame period = ROWS*DWELL cycles.
- Handshake-to-display latency: the frame appears at the first row-0 cycle after the next boundary. Worst case is 2*ROWS*DWELL cycles.
- frame_ready falls the cycle after acceptance. It rises the cycle after the boundary copy.
- DWELL = 1: the row changes every cycle and every row-ROWS-1 cycle is a boundary.

## Configuration
- MATRIX_BLANKING_EN defined: adds state BLANK, entered for exactly one cycle after each row's last dwell cycle.
  - In BLANK: row_sel all 1s, col_out 0. This prevents ghosting between rows.
  - Row period becomes DWELL+1 cycles.
  - The boundary copy happens in the BLANK cycle that follows row ROWS-1.
  - frame_start still marks the first cycle of row 0.
- Undefined: no BLANK state; behaviour is exactly as in Operation.

## Test plan
- Reset release, DWELL=4, no frame loaded: row_sel steps 1111110 -> 1111101 -> … -> 0111111 every 4 cycles. col_out stays 0, frame_start pulses every 28 cycles, frame_ready = 1.
- Load a frame with row r = r+1 (5-bit) mid-frame: frame_ready = 0 the next cycle. Row 0 of the next frame shows 00001 and row 6 shows 00111. frame_ready returns to 1 after the boundary.
- Second frame offered while pending = 1: held off (frame_ready = 0) until the boundary. It is then accepted and displayed one frame later, with no tearing of the first frame.
- frame_valid asserted exactly on the boundary cycle with pending = 0: the frame is captured but displayed only after the next boundary (28 cycles later at DWELL=4).
- rst pulsed during row 3 with pending = 1: the next cycle shows row_sel = 1111110, col_out = 0, and frame_ready = 1, and the pending frame is never displayed.
- MATRIX_BLANKING_EN, DWELL=4: a 1-cycle all-ones row_sel appears between rows and the frame period is 35 cycles.
